// File: rtl/store_write_buffer.sv
// store_write_buffer: posted-store FIFO between the core data port and data memory.
// Each store is captured in one cycle. Stores drain in program order over a
// valid/ready handshake.
// Optional store-to-load forwarding is enabled by defining STORE_BUF_FWD_EN.
// The default build leaves that macro undefined, which removes the forwarding
// ports and the compare logic entirely.
module store_write_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     memwrite,
   input  logic [AW-1:0]            dataadr,
   input  logic [DW-1:0]            writedata,
   output logic                     stall,
   output logic                     mem_valid,
   output logic [AW-1:0]            mem_addr,
   output logic [DW-1:0]            mem_wdata,
   input  logic                     mem_ready,
   output logic                     empty,
`ifdef STORE_BUF_FWD_EN
   input  logic [AW-1:0]            ld_addr,
   output logic                     fwd_hit,
   output logic [DW-1:0]            fwd_data,
`endif
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] addr_mem_r [DEPTH];
   logic [DW-1:0] data_mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;

   logic full_s;
   logic empty_s;
   logic push_s;
   logic pop_s;

   // Full and empty come from the occupancy count alone. Pointer equality is
   // ambiguous after wrap-around, and using count keeps mem_ready off the stall path.
   assign full_s  = (count_r == CW'(DEPTH));
   assign empty_s = (count_r == {CW{1'b0}});
   assign push_s  = memwrite && !full_s && !reset;
   assign pop_s   = !empty_s && mem_ready && !reset;

   assign stall     = full_s;
   assign empty     = empty_s;
   assign mem_valid = !empty_s;
   assign count     = count_r;
   assign mem_addr  = addr_mem_r[rd_ptr_r];
   assign mem_wdata = data_mem_r[rd_ptr_r];

   // Entry storage: write the accepted store at the tail; contents survive reset
   always_ff @(posedge clk) begin
      if (push_s) begin
         addr_mem_r[wr_ptr_r] <= dataadr;
         data_mem_r[wr_ptr_r] <= writedata;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

`ifdef STORE_BUF_FWD_EN
   logic [DEPTH-1:0] match_s;
   logic [DW-1:0]    fwd_data_s;
   logic             unused_ld_low;

   assign unused_ld_low = &{1'b0, ld_addr[1:0]};

   // Word-address compare against occupied entries only. The scan runs from
   // oldest to youngest, so the youngest match wins. The entry being popped is
   // still visible; the entry being pushed is not written yet, so it is not.
   always_comb begin
      match_s    = {DEPTH{1'b0}};
      fwd_data_s = {DW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         match_s[i] = (CW'(i) < count_r) &&
                      (addr_mem_r[PW'(rd_ptr_r + PW'(i))][AW-1:2] == ld_addr[AW-1:2]);
         fwd_data_s = match_s[i] ? data_mem_r[PW'(rd_ptr_r + PW'(i))] : fwd_data_s;
      end
   end

   assign fwd_hit  = |match_s;
   assign fwd_data = fwd_data_s;
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: vector table plus hand-written sequences for store_write_buffer.
// A scoreboard queue models the FIFO and checks drain order and status outputs.
module tb_store_write_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          memwrite;
   logic [AW-1:0] dataadr;
   logic [DW-1:0] writedata;
   logic          stall;
   logic          mem_valid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ready;
   logic          empty;
   logic [2:0]    count;
`ifdef STORE_BUF_FWD_EN
   logic [AW-1:0] ld_addr;
   logic          fwd_hit;
   logic [DW-1:0] fwd_data;
`endif

   store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .memwrite  (memwrite),
      .dataadr   (dataadr),
      .writedata (writedata),
      .stall     (stall),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .empty     (empty),
`ifdef STORE_BUF_FWD_EN
      .ld_addr   (ld_addr),
      .fwd_hit   (fwd_hit),
      .fwd_data  (fwd_data),
`endif
      .count     (count)
   );

   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;
   int pops   = 0;
   logic mon_en = 1'b0;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } entry_t;
   entry_t model_q[$];

   typedef struct {
      logic          rst;
      logic          mw;
      logic [AW-1:0] adr;
      logic [DW-1:0] wd;
      logic          rdy;
      logic [2:0]    exp_cnt;
      logic          exp_stall;
      logic          exp_empty;
      logic [AW-1:0] exp_adr;
      logic [DW-1:0] exp_wd;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic mw, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rdy);
      memwrite  = mw;
      dataadr   = a;
      writedata = d;
      mem_ready = rdy;
   endtask

   task automatic add_vec(input logic rst, input logic mw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic rdy, input logic [2:0] c, input logic st, input logic em,
                          input logic [AW-1:0] ea, input logic [DW-1:0] ed);
      vec_t v;
      v.rst = rst; v.mw = mw; v.adr = a; v.wd = d; v.rdy = rdy;
      v.exp_cnt = c; v.exp_stall = st; v.exp_empty = em; v.exp_adr = ea; v.exp_wd = ed;
      vecs.push_back(v);
   endtask

   // Scoreboard: compare status against the model away from the active edge, then
   // apply the transfers that the coming edge will perform.
   always @(negedge clk) begin
      if (mon_en) begin
         automatic int sz = model_q.size();
         automatic entry_t e;
         check("sb_count", 64'(count), 64'(sz));
         check("sb_mem_valid", 64'(mem_valid), 64'(sz > 0));
         check("sb_stall", 64'(stall), 64'(sz == DEPTH));
         check("sb_empty", 64'(empty), 64'(sz == 0));
         if (reset) begin
            model_q.delete();
         end else begin
            if (mem_ready && sz > 0) begin
               e = model_q.pop_front();
               check("drain_addr", 64'(mem_addr), 64'(e.addr));
               check("drain_data", 64'(mem_wdata), 64'(e.data));
               pops++;
            end
            if (memwrite && sz < DEPTH) begin
               e.addr = dataadr;
               e.data = writedata;
               model_q.push_back(e);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 1'b0);
`ifdef STORE_BUF_FWD_EN
      ld_addr = 32'h0;
`endif

      // Single store, then fill to full with a held fifth store, then drain
      add_vec(1'b1, 1'b0, 32'h0,  32'h0,   1'b0, 3'd0, 1'b0, 1'b1, 32'h0,  32'h0);
      add_vec(1'b0, 1'b1, 32'h64, 32'h7,   1'b0, 3'd1, 1'b0, 1'b0, 32'h64, 32'h7);
      add_vec(1'b0, 1'b0, 32'h0,  32'h0,   1'b1, 3'd0, 1'b0, 1'b1, 32'h0,  32'h0);
      add_vec(1'b0, 1'b1, 32'h0,  32'h100, 1'b0, 3'd1, 1'b0, 1'b0, 32'h0,  32'h100);
      add_vec(1'b0, 1'b1, 32'h4,  32'h101, 1'b0, 3'd2, 1'b0, 1'b0, 32'h0,  32'h100);
      add_vec(1'b0, 1'b1, 32'h8,  32'h102, 1'b0, 3'd3, 1'b0, 1'b0, 32'h0,  32'h100);
      add_vec(1'b0, 1'b1, 32'hC,  32'h103, 1'b0, 3'd4, 1'b1, 1'b0, 32'h0,  32'h100);
      add_vec(1'b0, 1'b1, 32'h10, 32'h104, 1'b0, 3'd4, 1'b1, 1'b0, 32'h0,  32'h100);
      add_vec(1'b0, 1'b1, 32'h10, 32'h104, 1'b0, 3'd4, 1'b1, 1'b0, 32'h0,  32'h100);
      add_vec(1'b0, 1'b1, 32'h10, 32'h104, 1'b0, 3'd4, 1'b1, 1'b0, 32'h0,  32'h100);
      add_vec(1'b0, 1'b1, 32'h10, 32'h104, 1'b1, 3'd3, 1'b0, 1'b0, 32'h4,  32'h101);
      add_vec(1'b0, 1'b1, 32'h10, 32'h104, 1'b1, 3'd3, 1'b0, 1'b0, 32'h8,  32'h102);
      add_vec(1'b0, 1'b0, 32'h0,  32'h0,   1'b1, 3'd2, 1'b0, 1'b0, 32'hC,  32'h103);
      add_vec(1'b0, 1'b0, 32'h0,  32'h0,   1'b1, 3'd1, 1'b0, 1'b0, 32'h10, 32'h104);
      add_vec(1'b0, 1'b0, 32'h0,  32'h0,   1'b1, 3'd0, 1'b0, 1'b1, 32'h0,  32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         reset = vecs[i].rst;
         drive(vecs[i].mw, vecs[i].adr, vecs[i].wd, vecs[i].rdy);
         cyc();
         if (i == 0) mon_en = 1'b1;
         check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_cnt));
         check($sformatf("vec%0d_stall", i), 64'(stall), 64'(vecs[i].exp_stall));
         check($sformatf("vec%0d_empty", i), 64'(empty), 64'(vecs[i].exp_empty));
         if (!vecs[i].exp_empty) begin
            check($sformatf("vec%0d_addr", i), 64'(mem_addr), 64'(vecs[i].exp_adr));
            check($sformatf("vec%0d_data", i), 64'(mem_wdata), 64'(vecs[i].exp_wd));
         end
      end
      reset = 1'b0;

      // Steady stream with memory always ready: occupancy stays at one across wraps
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, 32'h1000 + 32'(4 * i), 32'hA000 + 32'(i), 1'b1);
         cyc();
         check("stream_count", 64'(count), 64'd1);
         check("stream_head", 64'(mem_addr), 64'(32'h1000 + 32'(4 * i)));
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      cyc();
      check("stream_drained", 64'(count), 64'd0);

      // Reset while entries are pending discards them; inputs ignored in that cycle
      drive(1'b1, 32'h2000, 32'h1, 1'b0);
      cyc();
      drive(1'b1, 32'h2004, 32'h2, 1'b0);
      cyc();
      check("pre_reset_valid", 64'(mem_valid), 64'd1);
      reset = 1'b1;
      drive(1'b1, 32'h2008, 32'h3, 1'b1);
      cyc();
      reset = 1'b0;
      check("rst_count", 64'(count), 64'd0);
      check("rst_valid", 64'(mem_valid), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);
      drive(1'b1, 32'h200, 32'h55, 1'b0);
      cyc();
      check("post_rst_count", 64'(count), 64'd1);
      check("post_rst_addr", 64'(mem_addr), 64'h200);
      check("post_rst_data", 64'(mem_wdata), 64'h55);
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      cyc();
      check("post_rst_drain", 64'(empty), 64'd1);

      // Back-pressure: head stays stable while memory is not ready
      drive(1'b1, 32'h300, 32'hAA, 1'b0);
      cyc();
      drive(1'b1, 32'h304, 32'hBB, 1'b0);
      cyc();
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("hold_addr", 64'(mem_addr), 64'h300);
         check("hold_data", 64'(mem_wdata), 64'hAA);
         check("hold_count", 64'(count), 64'd2);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      cyc();
      check("hold_next_addr", 64'(mem_addr), 64'h304);
      cyc();
      check("hold_drained", 64'(empty), 64'd1);

`ifdef STORE_BUF_FWD_EN
      // Forwarding picks the youngest matching word; misses give zero data
      drive(1'b1, 32'h40, 32'h11, 1'b0);
      cyc();
      drive(1'b1, 32'h40, 32'h22, 1'b0);
      cyc();
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      ld_addr = 32'h40;
      #1;
      check("fwd_hit", 64'(fwd_hit), 64'd1);
      check("fwd_data", 64'(fwd_data), 64'h22);
      ld_addr = 32'h43;
      #1;
      check("fwd_hit_bytes", 64'(fwd_hit), 64'd1);
      ld_addr = 32'h44;
      #1;
      check("fwd_miss_hit", 64'(fwd_hit), 64'd0);
      check("fwd_miss_data", 64'(fwd_data), 64'h0);
      ld_addr = 32'h0;
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      cyc();
      cyc();
      check("fwd_drained", 64'(empty), 64'd1);
`endif

      drive(1'b0, 32'h0, 32'h0, 1'b0);
      cyc();
      check("model_empty", 64'(model_q.size()), 64'd0);
      check("total_pops", 64'(pops), 64'(6 + 12 + 1 + 2
`ifdef STORE_BUF_FWD_EN
                                            + 2
`endif
                                            ));
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
